mag_compare_seq: RTL

Parametrised, multi-cycle magnitude comparator that scans two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early at the first differing digit. It extends the team's combinational 6-bit A<=B comparator with arbitrary width, six selectable compare modes, optional signed compare and valid/ready handshakes on both sides. It sits between operand registers and the logic-unit result mux.

---
 rtl/mag_compare_seq_if.sv | 36 +++
 rtl/mag_compare_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/mag_compare_seq_if.sv
// Operand/result handshake bundle for mag_compare_seq.
// is_signed exists only when CMP_SIGNED_EN is defined.
interface mag_compare_seq_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
);
  localparam int CW = $clog2(WIDTH / DIGIT) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mode;
`ifdef CMP_SIGNED_EN
  logic             is_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [CW-1:0]    ncyc;

`ifdef CMP_SIGNED_EN
  modport master (output in_valid, a, b, mode, is_signed, out_ready,
                  input  in_ready, out_valid, result, lt, eq, gt, ncyc);
  modport slave  (input  in_valid, a, b, mode, is_signed, out_ready,
                  output in_ready, out_valid, result, lt, eq, gt, ncyc);
`else
  modport master (output in_valid, a, b, mode, out_ready,
                  input  in_ready, out_valid, result, lt, eq, gt, ncyc);
  modport slave  (input  in_valid, a, b, mode, out_ready,
                  output in_ready, out_valid, result, lt, eq, gt, ncyc);
`endif
endinterface

// File: rtl/mag_compare_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, early exit.
// Define CMP_SIGNED_EN to add the is_signed two's-complement compare.
module mag_compare_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mag_compare_seq_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                      state, state_nxt;
  logic [NDIG-1:0][DIGIT-1:0]  ra, rb;
  logic [2:0]                  rmode;
  logic [IW-1:0]               idx;
  logic [CW-1:0]               cnt;
  logic [WIDTH-1:0]            flip;
  logic [DIGIT-1:0]            da, db;
  logic                        dlt, dgt, last, accept;
  logic                        out_valid_q, result_q, lt_q, eq_q, gt_q;
  logic [CW-1:0]               ncyc_q;

  function automatic logic pred(input logic [2:0] m, input logic l, e, g);
    case (m)
      3'd0:    pred = e;
      3'd1:    pred = !e;
      3'd2:    pred = l;
      3'd3:    pred = l | e;
      3'd4:    pred = g;
      3'd5:    pred = g | e;
      default: pred = 1'b0;
    endcase
  endfunction

  // Offset-binary: flipping the sign bit makes signed order match unsigned order.
`ifdef CMP_SIGNED_EN
  assign flip = {bus.is_signed, {(WIDTH-1){1'b0}}};
`else
  assign flip = '0;
`endif

  assign da     = ra[idx];
  assign db     = rb[idx];
  assign dlt    = da < db;
  assign dgt    = da > db;
  assign last   = dlt | dgt | (idx == '0);
  assign accept = (state == IDLE) && bus.in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ra          <= '0;
      rb          <= '0;
      rmode       <= '0;
      idx         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      ncyc_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ra    <= bus.a ^ flip;
        rb    <= bus.b ^ flip;
        rmode <= bus.mode;
        idx   <= IW'(NDIG - 1);
        cnt   <= '0;
      end
      if (state == SCAN) begin
        cnt <= cnt + CW'(1);
        if (!last) idx <= idx - IW'(1);
        else begin
          out_valid_q <= 1'b1;
          lt_q        <= dlt;
          gt_q        <= dgt;
          eq_q        <= !dlt && !dgt;
          ncyc_q      <= cnt + CW'(1);
          result_q    <= pred(rmode, dlt, !dlt && !dgt, dgt);
        end
      end
      if (state == DONE && bus.out_ready) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.ncyc      = ncyc_q;
endmodule
